sevenseg_frame_reader: RTL and testbench
========================================

Name: sevenseg_frame_reader

Overview:
Receiving end of the seven-segment display path. Accepts a serial stream of 7-bit segment patterns and decodes each pattern back to a hex nibble. Assembles a frame of DIGITS nibbles into a parallel value. Used to read back what an adder/display datapath drives, so benches and self-check logic can recover the numeric result from segment codes.

Parameters:
DIGITS, 4, number of 7-bit digit patterns per frame; value width is 4*DIGITS.
TIMEOUT, 64, idle cycles (no seg_valid) allowed mid-frame before the frame is aborted; must be at least 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
seg_bit  input  1  serial segment bit; sampled only when seg_valid=1.
seg_valid  input  1  qualifies seg_bit; one bit is accepted per cycle while high.
frame_start  input  1  marks the bit accepted in the same cycle as the first bit of a frame; ignored when seg_valid=0.
value  output  4*DIGITS  last completed frame; first received digit sits in value[4*DIGITS-1 -: 4].
err_mask  output  DIGITS  bit i=1 means digit i of the last frame was not a legal hex pattern; bit DIGITS-1 is the first digit.
done  output  1  one-cycle pulse when value and err_mask update.
busy  output  1  high while a frame is in progress (state SHIFT).
aborted  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Segment encoding: active-high, pattern bit0=a … bit6=g. Each digit is sent MSB first (g first, a last), 7 accepted bits per digit.
- Decode table (pattern→nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
- Any other pattern decodes to nibble 0 and sets the corresponding err_mask bit.
- States:
  - IDLE: busy=0. seg_valid=1 with frame_start=1 captures the bit as bit6 of the first digit and moves to SHIFT. seg_valid=1 with frame_start=0 is discarded.
  - SHIFT: each accepted bit shifts into the digit register. A 3-bit counter runs 0..6 and a digit counter runs 0..DIGITS-1. On the 7th bit, the decoded nibble and error flag are written into the working registers at the current digit position.
  - On the 7th bit of the last digit, the state moves to DONE.
  - DONE: lasts one cycle. Working registers copy to value/err_mask, done=1, then the state returns to IDLE.
- Latency: done asserts the cycle after the final bit is accepted. value/err_mask are valid in that same cycle and hold until the next done.
- A bit presented in the DONE cycle with frame_start=1 starts a new frame: it is captured and the state goes to SHIFT instead of IDLE. Without frame_start, that bit is discarded.
- frame_start=1 with seg_valid=1 in SHIFT: aborted=1 that cycle and the partial frame is discarded. The bit becomes bit6 of digit 0 of a new frame, and the counters reset accordingly. value/err_mask are unchanged.
- Idle counter: cleared on every accepted bit in SHIFT and increments on each SHIFT cycle with seg_valid=0. When it reaches TIMEOUT: aborted=1, state→IDLE, value/err_mask unchanged.
- seg_valid gaps shorter than TIMEOUT stall the frame with no loss of data.
- Reset (any time, including mid-frame): state=IDLE, value=0, err_mask=0, done=0, busy=0, aborted=0, and all counters and working registers are 0. No done or aborted pulse is generated for a frame cut by reset.
- done and aborted never assert in the same cycle.

Test Plan:
- Frame "1","2","3","4" (06,5B,4F,66; 28 bits back-to-back, frame_start on the first) → done exactly 1 cycle after bit 28; value=16'h1234, err_mask=4'b0000.
- Frame 7F,77,39,71 sent with random seg_valid gaps ≤10 cycles → value=16'h8ACF, err_mask=0. busy stays high from the first bit until the DONE cycle; no aborted.
- Frame 06,00,4F,66 (second digit illegal) → value=16'h1034, err_mask=4'b0100.
- A new frame_start after 10 bits of frame A, then a full frame 3F,3F,3F,06 → aborted pulse at the restart bit. Only one done, with value=16'h0001.
- 12 bits sent, then seg_valid low for 64 cycles → aborted pulses once, busy=0, value keeps its previous value. Assert rst mid-frame in a separate run → all outputs 0 immediately.
- Two frames back-to-back, with the second frame_start in the DONE cycle → two done pulses 28 cycles apart, and each value is correct.

Source files
------------

// File: rtl/sevenseg_frame_reader_if.sv
// sevenseg_frame_reader_if: serial segment stream in, decoded frame out
//   seg_bit/seg_valid/frame_start: serial pattern bits, MSB (g) first, frame_start on the first bit
//   value/err_mask: last completed frame, first digit in the top nibble / top bit
//   done/aborted: one-cycle pulses for a completed / discarded frame; busy: frame in progress
interface sevenseg_frame_reader_if #(parameter int DIGITS = 4);
    logic                  seg_bit;
    logic                  seg_valid;
    logic                  frame_start;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     err_mask;
    logic                  done;
    logic                  busy;
    logic                  aborted;
    modport master (output seg_bit, seg_valid, frame_start, input value, err_mask, done, busy, aborted);
    modport slave (input seg_bit, seg_valid, frame_start, output value, err_mask, done, busy, aborted);
endinterface

// File: rtl/sevenseg_frame_reader.sv
// sevenseg_frame_reader: decodes a serial stream of 7-bit segment patterns into a DIGITS-nibble value
//   clk/rst: clock, asynchronous active-high reset
//   bus (slave): serial input bits and the decoded frame outputs, see sevenseg_frame_reader_if
module sevenseg_frame_reader #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    sevenseg_frame_reader_if.slave bus
);
    localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
    logic [1:0]          state;
    logic [5:0]          sr;
    logic [2:0]          bcnt;
    logic [DW-1:0]       dcnt;
    logic [TW-1:0]       idle;
    logic [4*DIGITS-1:0] wval, value_r, nval;
    logic [DIGITS-1:0]   werr, err_r, nerr;
    logic [6:0]          pat;
    logic [3:0]          nib;
    logic                bad, start, shift_in, timeout;
    // the bit on the wire completes the pattern when bcnt==6
    assign pat      = {sr, bus.seg_bit};
    // a frame_start bit is a (re)start in every state; in SHIFT it discards the partial frame
    assign start    = bus.seg_valid && bus.frame_start;
    assign shift_in = state == SHIFT && bus.seg_valid && !bus.frame_start;
    assign timeout  = state == SHIFT && !bus.seg_valid && idle == TW'(TIMEOUT - 1);
    always_comb begin
        nib = 4'h0;
        bad = 1'b0;
        case (pat)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: bad = 1'b1;
        endcase
    end
    // digit d of the frame lands in nibble DIGITS-1-d so the first digit ends up on top
    always_comb begin
        nval = wval;
        nerr = werr;
        for (int i = 0; i < DIGITS; i++)
            if (dcnt == DW'(DIGITS - 1 - i)) begin
                nval[4*i +: 4] = nib;
                nerr[i]        = bad;
            end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bcnt    <= '0;
            dcnt    <= '0;
            idle    <= '0;
            wval    <= '0;
            werr    <= '0;
            value_r <= '0;
            err_r   <= '0;
        end else if (start) begin
            state <= SHIFT;
            sr    <= {5'b0, bus.seg_bit};
            bcnt  <= 3'd1;
            dcnt  <= '0;
            idle  <= '0;
            wval  <= '0;
            werr  <= '0;
        end else if (shift_in) begin
            sr   <= {sr[4:0], bus.seg_bit};
            idle <= '0;
            if (bcnt == 3'd6) begin
                bcnt <= '0;
                wval <= nval;
                werr <= nerr;
                if (dcnt == DW'(DIGITS - 1)) begin
                    dcnt    <= '0;
                    state   <= DONE;
                    value_r <= nval;
                    err_r   <= nerr;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end else begin
                bcnt <= bcnt + 3'd1;
            end
        end else if (state == SHIFT && !bus.seg_valid) begin
            idle  <= timeout ? '0 : idle + 1'b1;
            state <= timeout ? IDLE : SHIFT;
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
    assign bus.value    = value_r;
    assign bus.err_mask = err_r;
    assign bus.done     = state == DONE;
    assign bus.busy     = state == SHIFT;
    assign bus.aborted  = (state == SHIFT && start) || timeout;
endmodule

// File: tb/tb_sevenseg_frame_reader.sv
// tb_sevenseg_frame_reader: directed and randomized frames checked against a table-lookup decode model
`timescale 1ns/1ps
module tb_sevenseg_frame_reader;
    localparam int DIGITS = 4, TIMEOUT = 64, W = 4 * DIGITS;
    logic clk = 1'b0;
    logic rst = 1'b1;
    sevenseg_frame_reader_if #(.DIGITS(DIGITS)) bus();
    sevenseg_frame_reader #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int tests = 0, fails = 0;
    int cyc = 0, ndone = 0, nabort = 0, nboth = 0, done_cyc = 0, abort_cyc = 0;
    logic [6:0] legal [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] fr [DIGITS];
    always @(negedge clk) begin
        cyc++;
        if (bus.done) begin ndone++; done_cyc = cyc; end
        if (bus.aborted) begin nabort++; abort_cyc = cyc; end
        if (bus.done && bus.aborted) nboth++;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic void model(output logic [W-1:0] v, output logic [DIGITS-1:0] e);
        v = '0;
        e = '0;
        for (int d = 0; d < DIGITS; d++) begin
            logic [3:0] n;
            logic b;
            n = 4'h0;
            b = 1'b1;
            for (int k = 0; k < 16; k++)
                if (legal[k] == fr[d]) begin n = 4'(k); b = 1'b0; end
            v = {v[W-5:0], n};
            e = {e[DIGITS-2:0], b};
        end
    endfunction
    task automatic drive(input logic v, input logic b, input logic fs);
        bus.seg_valid   = v;
        bus.seg_bit     = b;
        bus.frame_start = fs;
        @(posedge clk);
        #1;
    endtask
    task automatic send_frame(input int maxgap, input string tag);
        logic [W-1:0] ev;
        logic [DIGITS-1:0] ee;
        int busy_bad, n0;
        busy_bad = 0;
        n0 = ndone;
        model(ev, ee);
        for (int d = 0; d < DIGITS; d++)
            for (int k = 6; k >= 0; k--) begin
                if (!(d == 0 && k == 6))
                    repeat ($urandom_range(maxgap, 0)) begin
                        drive(1'b0, 1'($urandom), 1'($urandom));
                        if (!bus.busy) busy_bad++;
                    end
                drive(1'b1, fr[d][k], d == 0 && k == 6);
                if (!(d == DIGITS - 1 && k == 0) && !bus.busy) busy_bad++;
            end
        bus.seg_valid   = 1'b0;
        bus.frame_start = 1'b0;
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " value"}, 32'(bus.value), 32'(ev));
        chk({tag, " err_mask"}, 32'(bus.err_mask), 32'(ee));
        chk({tag, " busy in DONE"}, 32'(bus.busy), 32'd0);
        chk({tag, " busy held"}, busy_bad, 0);
        @(negedge clk);
        #1;
        chk({tag, " single done"}, ndone - n0, 1);
    endtask
    task automatic set_frame(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
        fr[0] = a; fr[1] = b; fr[2] = c; fr[3] = d;
    endtask
    initial begin
        int na0, nd0, d1;
        bus.seg_valid = 1'b0;
        bus.seg_bit = 1'b0;
        bus.frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset value", 32'(bus.value), 32'd0);
        chk("reset err_mask", 32'(bus.err_mask), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset aborted", 32'(bus.aborted), 32'd0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        chk("idle bit ignored", 32'(bus.busy), 32'd0);
        set_frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        send_frame(0, "f1234");
        chk("f1234 const", 32'(bus.value), 32'h1234);
        drive(1'b0, 1'b0, 1'b0);
        chk("done one cycle", 32'(bus.done), 32'd0);
        na0 = nabort;
        set_frame(7'h7F, 7'h77, 7'h39, 7'h71);
        send_frame(10, "f8acf");
        chk("f8acf const", 32'(bus.value), 32'h8ACF);
        chk("f8acf no abort", nabort - na0, 0);
        set_frame(7'h06, 7'h00, 7'h4F, 7'h66);
        send_frame(3, "fillegal");
        chk("fillegal const", 32'(bus.value), 32'h1034);
        chk("fillegal mask", 32'(bus.err_mask), 32'b0100);
        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < DIGITS; d++)
                fr[d] = ($urandom_range(3, 0) != 0) ? legal[$urandom_range(15, 0)] : 7'($urandom);
            send_frame(6, $sformatf("rand%0d", r));
        end
        na0 = nabort;
        nd0 = ndone;
        drive(1'b1, 1'($urandom), 1'b1);
        repeat (9) drive(1'b1, 1'($urandom), 1'b0);
        set_frame(7'h3F, 7'h3F, 7'h3F, 7'h06);
        send_frame(0, "restart");
        chk("restart one abort", nabort - na0, 1);
        chk("restart abort position", done_cyc - abort_cyc, 28);
        chk("restart one done", ndone - nd0, 1);
        chk("restart const", 32'(bus.value), 32'h0001);
        na0 = nabort;
        nd0 = ndone;
        drive(1'b1, 1'($urandom), 1'b1);
        repeat (11) drive(1'b1, 1'($urandom), 1'b0);
        repeat (TIMEOUT - 1) drive(1'b0, 1'($urandom), 1'($urandom));
        chk("timeout busy before", 32'(bus.busy), 32'd1);
        chk("timeout aborted at limit", 32'(bus.aborted), 32'd1);
        chk("timeout no early abort", nabort - na0, 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("timeout busy after", 32'(bus.busy), 32'd0);
        chk("timeout aborted once", nabort - na0, 1);
        chk("timeout value kept", 32'(bus.value), 32'h0001);
        chk("timeout err kept", 32'(bus.err_mask), 32'd0);
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        chk("timeout no repeat", nabort - na0, 1);
        chk("timeout no done", ndone - nd0, 0);
        set_frame(legal[$urandom_range(15, 0)], legal[$urandom_range(15, 0)], 7'h7D, legal[$urandom_range(15, 0)]);
        send_frame(0, "b2b1");
        d1 = done_cyc;
        set_frame(legal[$urandom_range(15, 0)], 7'($urandom), legal[$urandom_range(15, 0)], 7'h6D);
        send_frame(0, "b2b2");
        chk("b2b spacing", done_cyc - d1, 28);
        na0 = nabort;
        nd0 = ndone;
        drive(1'b1, 1'($urandom), 1'b1);
        repeat (14) drive(1'b1, 1'($urandom), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst value", 32'(bus.value), 32'd0);
        chk("rst err_mask", 32'(bus.err_mask), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst aborted", 32'(bus.aborted), 32'd0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) drive(1'b1, 1'($urandom), 1'b0);
        chk("rst no pulses", (nabort - na0) + (ndone - nd0), 0);
        chk("rst idle after", 32'(bus.busy), 32'd0);
        set_frame(7'h79, 7'h5E, 7'h7C, 7'h6F);
        send_frame(4, "after rst");
        chk("after rst const", 32'(bus.value), 32'hEDB9);
        chk("done/aborted exclusive", nboth, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
